// File: rtl/temp_table_builder.sv
// Writer side of the temperature lookup RAM: walks all 512 {mode, temp} addresses,
// computes each rounded conversion with a fixed-latency restoring divider and writes it.
module temp_table_builder #(
    parameter int unsigned F_OFFSET  = 32,
    parameter int unsigned DIV_ITERS = 12
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    output logic       BUSY,
    output logic       DONE,
    output logic       WR_EN,
    output logic [8:0] WR_ADDR,
    output logic [7:0] WR_DATA
);

    localparam int unsigned NW = DIV_ITERS;
    localparam int unsigned CW = $clog2(DIV_ITERS + 1);

    typedef enum logic [2:0] {IDLE, SETUP, DIVIDE, WRITE, FIN} state_t;

    state_t          state;
    logic [8:0]      addr;
    logic [NW-1:0]   num;
    logic [NW-1:0]   quo;
    logic [3:0]      div;
    logic [3:0]      rem;
    logic [CW-1:0]   iter;

    logic [7:0]      t;
    logic [NW-1:0]   n_load;
    logic [3:0]      d_load;
    logic [4:0]      trial;
    logic            take;
    logic [3:0]      rem_next;
    logic [NW-1:0]   quo_next;
    logic [8:0]      sum;

    assign t = addr[7:0];

    // Rounding bias folded into the numerator: +2 over /5 and +4 over /9 give nearest integer.
    always_comb begin
        n_load = '0;
        d_load = 4'd9;
        if (addr[8]) begin
            n_load = NW'(9) * NW'(t) + NW'(2);
            d_load = 4'd5;
        end else if (t > 8'(F_OFFSET)) begin
            n_load = NW'(5) * NW'(t - 8'(F_OFFSET)) + NW'(4);
        end
    end

    always_comb begin
        trial    = {rem, num[NW-1]};
        take     = (trial >= {1'b0, div});
        rem_next = take ? 4'(trial - {1'b0, div}) : trial[3:0];
        quo_next = {quo[NW-2:0], take};
        sum      = quo_next[8:0] + 9'(F_OFFSET);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            WR_EN   <= 1'b0;
            WR_ADDR <= '0;
            WR_DATA <= '0;
            addr    <= '0;
            num     <= '0;
            quo     <= '0;
            div     <= '0;
            rem     <= '0;
            iter    <= '0;
        end else begin
            DONE  <= 1'b0;
            WR_EN <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        addr  <= '0;
                        BUSY  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    num   <= n_load;
                    div   <= d_load;
                    quo   <= '0;
                    rem   <= '0;
                    iter  <= '0;
                    state <= DIVIDE;
                end
                DIVIDE: begin
                    num  <= {num[NW-2:0], 1'b0};
                    rem  <= rem_next;
                    quo  <= quo_next;
                    iter <= iter + 1'b1;
                    // Final quotient bit is taken combinationally so the write can register now.
                    if (iter == CW'(DIV_ITERS - 1)) begin
                        state   <= WRITE;
                        WR_EN   <= 1'b1;
                        WR_ADDR <= addr;
                        if (addr[8])
                            WR_DATA <= (sum > 9'd255) ? 8'hFF : sum[7:0];
                        else
                            WR_DATA <= quo_next[7:0];
                    end
                end
                WRITE: begin
                    if (addr == 9'd511) begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= FIN;
                    end else begin
                        addr  <= addr + 9'd1;
                        state <= SETUP;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_table_builder.sv
// Scoreboard bench: expected writes (address, value, cycle) are queued per run from a
// rounding model; a negedge monitor pops and compares every DUT write and the DONE pulse.
module tb_temp_table_builder;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic       BUSY;
    logic       DONE;
    logic       WR_EN;
    logic [8:0] WR_ADDR;
    logic [7:0] WR_DATA;

    temp_table_builder #(.F_OFFSET(32), .DIV_ITERS(12)) dut (
        .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   t0     = 0;
    bit   run_on = 1'b0;
    int   busy_cnt, wr_cnt;
    logic [7:0] dut_tab [512];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference conversion with explicit nearest-integer rounding on quotient/remainder.
    function automatic int model(input int a);
        int t, q, r, v;
        t = a % 256;
        if (a >= 256) begin
            q = (9 * t) / 5;
            r = (9 * t) % 5;
            if (2 * r > 5) q++;
            v = q + 32;
            if (v > 255) v = 255;
        end else if (t <= 32) begin
            v = 0;
        end else begin
            q = (5 * (t - 32)) / 9;
            r = (5 * (t - 32)) % 9;
            if (r >= 5) q++;
            v = q;
        end
        return v;
    endfunction

    always @(negedge CLK) begin
        int   rel;
        exp_t e;
        if (run_on) begin
            rel = cyc - t0;
            if (BUSY === 1'b1) busy_cnt++;
            if (WR_EN === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "extra_write", int'(WR_ADDR), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk(int'(WR_ADDR) == e.addr, "wr_addr", int'(WR_ADDR), e.addr);
                    chk(int'(WR_DATA) == e.data, "wr_data", int'(WR_DATA), e.data);
                    chk(rel == e.cyc, "wr_cycle", rel, e.cyc);
                    dut_tab[WR_ADDR] = WR_DATA;
                    wr_cnt++;
                end
            end
            if (DONE === 1'b1) begin
                chk(rel == 7169, "done_cycle", rel, 7169);
                chk(wr_cnt == 512, "wr_count", wr_cnt, 512);
                chk(busy_cnt == 7168, "busy_cycles", busy_cnt, 7168);
                chk(exp_q.size() == 0, "missing_writes", exp_q.size(), 0);
                run_on = 1'b0;
            end
        end else if (DONE === 1'b1 || WR_EN === 1'b1) begin
            chk(1'b0, "spurious_output", int'({DONE, WR_EN}), 0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic start_run();
        exp_t e;
        START = 1'b1;
        t0 = cyc;
        exp_q.delete();
        for (int a = 0; a < 512; a++) begin
            e.addr = a;
            e.data = model(a);
            e.cyc  = 14 * (a + 1);
            exp_q.push_back(e);
        end
        busy_cnt = 0;
        wr_cnt   = 0;
        run_on   = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_done(input int p1, input int p2);
        int n = 0;
        while (run_on && n < 7400) begin
            tick();
            n++;
            START = ((cyc - t0) == p1 || (cyc - t0) == p2);
        end
        START = 1'b0;
        if (run_on) begin
            chk(1'b0, "run_timeout", n, 7169);
            run_on = 1'b0;
        end
    endtask

    int sa[12] = '{256, 293, 356, 380, 381, 511, 0, 31, 32, 98, 212, 255};
    int sv[12] = '{32, 99, 212, 255, 255, 255, 0, 0, 0, 37, 100, 124};

    initial begin
        RST   = 1'b1;
        START = 1'b1;
        repeat (3) begin
            tick();
            chk(BUSY === 1'b0, "rst_busy", int'(BUSY), 0);
            chk(DONE === 1'b0 && WR_EN === 1'b0, "rst_done_wren", int'({DONE, WR_EN}), 0);
            chk(WR_ADDR === 9'd0 && WR_DATA === 8'd0, "rst_addr_data",
                int'(WR_ADDR), 0);
        end
        RST   = 1'b0;
        START = 1'b0;
        repeat (3) tick();
        chk(BUSY === 1'b0, "idle_no_start", int'(BUSY), 0);

        repeat ($urandom_range(1, 20)) tick();
        start_run();
        wait_done(100, 5000);
        foreach (sa[i])
            chk(int'(dut_tab[sa[i]]) == sv[i], $sformatf("table_%0d", sa[i]),
                int'(dut_tab[sa[i]]), sv[i]);

        // Interrupted run: reset at cycle 700, then restart 10 cycles later.
        repeat ($urandom_range(1, 20)) tick();
        start_run();
        for (int i = 1; i < 700; i++) tick();
        RST = 1'b1;
        tick();
        run_on = 1'b0;
        exp_q.delete();
        RST = 1'b0;
        chk(BUSY === 1'b0 && WR_EN === 1'b0 && DONE === 1'b0, "midrst_ctrl",
            int'({BUSY, WR_EN, DONE}), 0);
        chk(WR_ADDR === 9'd0 && WR_DATA === 8'd0, "midrst_addr_data", int'(WR_ADDR), 0);
        repeat (9) tick();
        start_run();
        wait_done($urandom_range(2, 7000), $urandom_range(2, 7000));

        repeat ($urandom_range(1, 20)) tick();
        start_run();
        wait_done($urandom_range(2, 7100), $urandom_range(2, 7100));

        repeat (20) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/temp_table_builder.md
Name: temp_table_builder

Overview:
- Generates the 512-entry temperature conversion table and writes it into the synchronous RAM that the temperature converter reads.
- Read address is {mode, temp}. mode=1 selects C->F; mode=0 selects F->C.
- The block is the writer side of that lookup interface: a sequential FSM with a multi-cycle restoring divider that computes every entry and issues one write per entry.
- It runs once per start pulse, normally right after power-up, before the converter is used.

Parameters:
- F_OFFSET, 32, Fahrenheit offset added (C->F) or subtracted (F->C).
- DIV_ITERS, 12, restoring-divider iterations. Must cover a 12-bit numerator; max numerator is 9*255+2 = 2297.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- START  in  1  sampled only in IDLE. A 1 begins table generation.
- BUSY  out  1  high from the cycle after START is accepted through the last write cycle.
- DONE  out  1  single-cycle pulse after the final write.
- WR_EN  out  1  RAM write strobe, one cycle per entry.
- WR_ADDR  out  9  {mode, temp}. Bit 8 = mode.
- WR_DATA  out  8  converted value for WR_ADDR.

Behaviour:
- Reset (RST=1 at a rising edge): state=IDLE, BUSY=0, DONE=0, WR_EN=0, WR_ADDR=0, WR_DATA=0, internal address counter=0. Reset overrides START.
- States: IDLE, SETUP, DIVIDE, WRITE, FIN.
- IDLE:
  - Outputs low.
  - START=1 -> SETUP with addr=0.
  - START is ignored in every other state.
- SETUP (1 cycle): load numerator N and divisor D from addr.
  - mode=1 (C->F), t=addr[7:0]: N = 9*t + 2, D = 5.
  - mode=0 (F->C), t=addr[7:0]: if t <= F_OFFSET then N=0, else N = 5*(t-F_OFFSET) + 4; D = 9.
- DIVIDE (exactly DIV_ITERS cycles): restoring shift-subtract, MSB first, producing quotient Q. No early exit; latency is fixed.
- WRITE (1 cycle):
  - WR_EN=1, WR_ADDR=addr.
  - WR_DATA: mode=1 -> min(Q + F_OFFSET, 255); mode=0 -> Q (max 124, no saturation needed).
  - The add uses 9-bit width before saturating.
  - Then: if addr==511 -> FIN; else addr+1 -> SETUP.
- FIN (1 cycle): DONE=1, BUSY=0 -> IDLE.
- Rounding: nearest integer.
  - C->F has no ties (divisor 5).
  - F->C rounds fraction >= 5/9 up.
- Address order: ascending 0..511. All F->C entries first, then C->F.
- Timing, with START accepted at edge 0:
  - BUSY=1 during cycles 1..7168.
  - Entry k is written in cycle 14*(k+1).
  - Last write in cycle 7168; DONE=1 in cycle 7169.
  - Exactly 512 WR_EN pulses per run.
- WR_ADDR/WR_DATA are don't-care when WR_EN=0 but must hold their last written value; no X.
- Reset mid-run: next cycle all outputs are at reset values, no DONE is produced, and the partial table is left as is. A new START restarts from addr 0.
- START held high continuously: one run, then a new run begins in the cycle after FIN returns to IDLE.

Test Plan:
- Reset: RST=1 for 3 cycles with START=1 -> BUSY=DONE=WR_EN=0, WR_ADDR=0, WR_DATA=0. After RST deasserts, the first START pulse begins the run.
- Timing: START pulse at cycle 0 -> first WR_EN at cycle 14 with WR_ADDR=0, WR_DATA=0. Last WR_EN at cycle 7168 with WR_ADDR=511. DONE single pulse at cycle 7169. WR_EN count = 512; BUSY high exactly 7168 cycles.
- C->F values (captured from writes):
  - addr 256 -> 32
  - addr 293 (37C) -> 99
  - addr 356 (100C) -> 212
  - addr 380 (124C) -> 255
  - addr 381 (125C) -> 255 (saturated)
  - addr 511 -> 255
- F->C values:
  - addr 0 -> 0
  - addr 31 -> 0
  - addr 32 -> 0
  - addr 98 -> 37
  - addr 212 -> 100
  - addr 255 -> 124
  - Full 512-entry compare against a bench model using the same rounding formulas.
- START while BUSY: pulse START at cycles 100 and 5000 -> no effect on address sequence or timing; DONE still at 7169, with no second run.
- Reset mid-run: RST=1 at cycle 700 -> WR_EN=0, BUSY=0 next cycle, no DONE. A START 10 cycles later -> first write addr 0 exactly 14 cycles after acceptance, and the run completes normally.
